debug_frame_sequencer: RTL and testbench
========================================

# debug_frame_sequencer

Parametrised debug-unit controller that, on a matching request from the debug interface, walks every entry of one MIPS debug source (register file, data memory or pipeline latch bank) and streams each entry to the interface as NB_LATCH-wide frames under a valid/ready handshake. It supersedes the single-source, fixed-timer controllers by generalising:
- entry count (N_ENTRIES, with address generation);
- entry width (any NB_INPUT_SIZE, with exact padding);
- flow control (backpressure from the interface, abort, completion pulse).

It sits between the MIPS debug read ports and the UART/debug interface frame mux, one instance per source.

## Interface
Parameters:
- NB_LATCH, 32, frame width in bits
- NB_INPUT_SIZE, 32, width of one source entry
- N_ENTRIES, 32, number of entries to dump (1 = single latch)
- NB_ADDR, 5, entry address width; requirement: 2^NB_ADDR >= N_ENTRIES
- CONTROLLER_ID, 6'b000000, request code this instance answers

Ports (reset i_reset, synchronous, active-high; clock i_clock):
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_request_valid  in  1  one-cycle request strobe
- i_request_select  in  6  requested controller ID
- i_abort  in  1  cancel dump in progress
- i_data_from_mips  in  NB_INPUT_SIZE  entry at o_addr, combinational from source
- i_frame_ready  in  1  interface accepts o_frame this cycle
- o_frame  out  NB_LATCH  current frame
- o_frame_valid  out  1  o_frame is valid
- o_addr  out  NB_ADDR  entry address driven to source
- o_busy  out  1  dump in progress (any state except IDLE)
- o_done  out  1  one-cycle pulse after the last frame is accepted

## Operation
- Derived constants:
  - NB_FRAMES = ceil(NB_INPUT_SIZE/NB_LATCH).
  - NB_PAD = NB_FRAMES*NB_LATCH - NB_INPUT_SIZE. NB_PAD is 0 when the entry width divides evenly; no extra frame is generated in that case.
- Entry layout: the padded entry is {data, NB_PAD zeros}. Frame 0 is the MSB slice; the last frame carries the LSBs followed by the zero pad.
- States:
  - IDLE
    - Leave IDLE only when i_request_valid=1 and i_request_select==CONTROLLER_ID.
    - On that request: o_addr<=0, go to FETCH.
    - All other requests are ignored.
  - FETCH (exactly 1 cycle)
    - Latch i_data_from_mips into the shadow register.
    - Set frame index <= 0, go to SEND.
  - SEND
    - o_frame_valid=1 and o_frame=slice[index] of the shadow register.
    - On i_frame_ready=1 with index < NB_FRAMES-1: index++.
    - On i_frame_ready=1 with the last slice and o_addr < N_ENTRIES-1: o_addr++, go to FETCH.
    - On i_frame_ready=1 with the last slice of the last entry: go to DONE.
  - DONE: o_done=1 for one cycle, then IDLE.
- Handshake rules:
  - A frame transfers on a cycle where o_frame_valid & i_frame_ready.
  - o_frame is held stable while valid and not ready.
  - o_frame_valid is never dropped without a transfer, except on abort or reset.
- Shadow register: the source may change during SEND without affecting the frames.
- Abort: i_abort=1 in any non-IDLE state forces IDLE on the next edge. No o_done pulse; o_addr is held at its last value. Abort has priority over a same-cycle transfer: that transfer still counts at the interface, but the sequencer discards it.
- Requests while o_busy=1 are ignored, including a matching ID. There is no queueing.
- Counter sizing and wrap:
  - o_addr never wraps; it stops at N_ENTRIES-1.
  - The frame index is clog2(NB_FRAMES) bits wide, minimum 1 bit.

## Timing
- Reset values: state=IDLE, o_frame_valid=0, o_busy=0, o_done=0, o_addr=0, o_frame=0 (shadow cleared).
- Request latency: request sampled at edge 0, FETCH in cycle 1, first o_frame_valid in cycle 2.
- With i_frame_ready tied high, each entry costs 1+NB_FRAMES cycles.
- Total dump time with ready tied high: N_ENTRIES*(1+NB_FRAMES)+1 cycles from the request edge to the o_done pulse.
- o_addr changes on the edge entering FETCH. The source has one full cycle of combinational settle before capture.
- Reset mid-dump: IDLE on the next edge; all outputs return to their reset values.
- Reset has priority over abort, and abort has priority over requests.

## Structure
- Shared package debug_pkg:
  - state enum localparams ST_IDLE/ST_FETCH/ST_SEND/ST_DONE;
  - clog2 function;
  - NB_FRAMES/NB_PAD computation macros;
  - the controller ID codes for regfile, memory and latches.
- One sub-module, debug_frame_slicer: a combinational unit that pads the entry and selects slice[index]. It is parametrised by NB_LATCH and NB_INPUT_SIZE, and is reused by the interface-side frame mux.

## Test plan
- Regfile dump, defaults, ready=1, entry k = 0xA5000000+k: expect 32 frames in order 0xA5000000..0xA500001F, and o_done exactly 65 cycles after the request edge.
- NB_INPUT_SIZE=48, N_ENTRIES=1, data 0x123456789ABC: expect frame 0x12345678, then 0x9ABC0000, then o_done.
- Backpressure: ready toggles 1-0-0-1: o_frame stays stable and valid while ready=0, and no frame is skipped or duplicated.
- Abort during entry 3, frame 0: o_busy=0 and o_frame_valid=0 next cycle, no o_done; a new matching request restarts at addr 0.
- Mismatched ID (select=6'b100000) in IDLE: no state change. Matching request while busy: ignored, and the dump count is unchanged.
- Reset asserted mid-SEND with ready=0: all outputs at reset values next cycle, then a clean full dump afterwards.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the MIPS debug-unit controllers: FSM states,
// controller ID codes and the frame-geometry helpers used by sequencer and frame mux.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [5:0] CTRL_ID_REGFILE = 6'b000000;
    localparam logic [5:0] CTRL_ID_MEMORY  = 6'b000001;
    localparam logic [5:0] CTRL_ID_LATCHES = 6'b000010;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int nb_frames(input int nb_input, input int nb_latch);
        return (nb_input + nb_latch - 1) / nb_latch;
    endfunction

    function automatic int nb_pad(input int nb_input, input int nb_latch);
        return nb_frames(nb_input, nb_latch) * nb_latch - nb_input;
    endfunction

    // A single-frame entry still carries a 1-bit index.
    function automatic int idx_width(input int frames);
        return (clog2(frames) < 1) ? 1 : clog2(frames);
    endfunction

endpackage

// File: rtl/debug_frame_sequencer_if.sv
// Request / frame-stream bundle between a debug source sequencer and the
// debug interface. Signal names keep the controller's established port names.
interface debug_frame_sequencer_if #(
    parameter int NB_LATCH      = 32,
    parameter int NB_INPUT_SIZE = 32,
    parameter int NB_ADDR       = 5
);
    logic                     i_request_valid;
    logic [5:0]               i_request_select;
    logic                     i_abort;
    logic [NB_INPUT_SIZE-1:0] i_data_from_mips;
    logic                     i_frame_ready;
    logic [NB_LATCH-1:0]      o_frame;
    logic                     o_frame_valid;
    logic [NB_ADDR-1:0]       o_addr;
    logic                     o_busy;
    logic                     o_done;

    modport master (
        output i_request_valid, i_request_select, i_abort, i_data_from_mips, i_frame_ready,
        input  o_frame, o_frame_valid, o_addr, o_busy, o_done
    );

    modport slave (
        input  i_request_valid, i_request_select, i_abort, i_data_from_mips, i_frame_ready,
        output o_frame, o_frame_valid, o_addr, o_busy, o_done
    );
endinterface

// File: rtl/debug_frame_sequencer_slicer.sv
// Pads one source entry with trailing zeros to a whole number of frames and
// selects frame[index], frame 0 being the MSB slice.
module debug_frame_slicer
    import debug_pkg::*;
#(
    parameter int NB_LATCH      = 32,
    parameter int NB_INPUT_SIZE = 32,
    localparam int NB_FRAMES    = nb_frames(NB_INPUT_SIZE, NB_LATCH),
    localparam int NB_IDX       = idx_width(NB_FRAMES)
) (
    input  logic [NB_INPUT_SIZE-1:0] entry,
    input  logic [NB_IDX-1:0]        index,
    output logic [NB_LATCH-1:0]      frame
);
    localparam int NB_PAD = nb_pad(NB_INPUT_SIZE, NB_LATCH);
    localparam int PAD_W  = NB_FRAMES * NB_LATCH;

    logic [PAD_W-1:0] padded;
    int               sel;

    always_comb begin
        padded = PAD_W'(entry) << NB_PAD;
        sel    = NB_FRAMES - 1 - int'(index);
        if (sel < 0) sel = 0;
        frame  = NB_LATCH'(padded >> (sel * NB_LATCH));
    end
endmodule

// File: rtl/debug_frame_sequencer.sv
// Walks all N_ENTRIES entries of one debug source on a matching request and
// streams each as NB_FRAMES frames under valid/ready, with abort and done pulse.
module debug_frame_sequencer
    import debug_pkg::*;
#(
    parameter int         NB_LATCH      = 32,
    parameter int         NB_INPUT_SIZE = 32,
    parameter int         N_ENTRIES     = 32,
    parameter int         NB_ADDR       = 5,
    parameter logic [5:0] CONTROLLER_ID = 6'b000000
) (
    input logic                   i_clock,
    input logic                   i_reset,
    debug_frame_sequencer_if.slave bus
);
    localparam int NB_FRAMES = nb_frames(NB_INPUT_SIZE, NB_LATCH);
    localparam int NB_IDX    = idx_width(NB_FRAMES);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_ENTRIES - 1);
    localparam logic [NB_IDX-1:0]  LAST_IDX  = NB_IDX'(NB_FRAMES - 1);

    state_t                   state, state_n;
    logic [NB_ADDR-1:0]       addr, addr_n;
    logic [NB_IDX-1:0]        idx, idx_n;
    logic [NB_INPUT_SIZE-1:0] shadow, shadow_n;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state  <= ST_IDLE;
            addr   <= '0;
            idx    <= '0;
            shadow <= '0;
        end else begin
            state  <= state_n;
            addr   <= addr_n;
            idx    <= idx_n;
            shadow <= shadow_n;
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = addr;
        idx_n    = idx;
        shadow_n = shadow;
        case (state)
            ST_IDLE: begin
                if (bus.i_request_valid && bus.i_request_select == CONTROLLER_ID) begin
                    addr_n  = '0;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                shadow_n = bus.i_data_from_mips;
                idx_n    = '0;
                state_n  = ST_SEND;
            end
            ST_SEND: begin
                if (bus.i_frame_ready) begin
                    if (idx != LAST_IDX) begin
                        idx_n = idx + NB_IDX'(1);
                    end else if (addr != LAST_ADDR) begin
                        addr_n  = addr + NB_ADDR'(1);
                        state_n = ST_FETCH;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // Abort drops whatever this cycle decided, including a same-cycle transfer.
        if (bus.i_abort && state != ST_IDLE) begin
            state_n  = ST_IDLE;
            addr_n   = addr;
            idx_n    = idx;
            shadow_n = shadow;
        end
    end

    debug_frame_slicer #(
        .NB_LATCH      (NB_LATCH),
        .NB_INPUT_SIZE (NB_INPUT_SIZE)
    ) u_slicer (
        .entry (shadow),
        .index (idx),
        .frame (bus.o_frame)
    );

    assign bus.o_frame_valid = (state == ST_SEND);
    assign bus.o_busy        = (state != ST_IDLE);
    assign bus.o_done        = (state == ST_DONE);
    assign bus.o_addr        = addr;
endmodule

// File: tb/tb_debug_frame_sequencer.sv
// Scoreboard bench: a 32x32 regfile instance and a 4x48-bit two-frame instance.
module tb_debug_frame_sequencer;
    import debug_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b;

    debug_frame_sequencer_if #(.NB_LATCH(32), .NB_INPUT_SIZE(32), .NB_ADDR(5)) ifa ();
    debug_frame_sequencer_if #(.NB_LATCH(32), .NB_INPUT_SIZE(48), .NB_ADDR(2)) ifb ();

    debug_frame_sequencer #(.NB_LATCH(32), .NB_INPUT_SIZE(32), .N_ENTRIES(32), .NB_ADDR(5),
                            .CONTROLLER_ID(CTRL_ID_REGFILE))
        dut_a (.i_clock(clk), .i_reset(rst_a), .bus(ifa));
    debug_frame_sequencer #(.NB_LATCH(32), .NB_INPUT_SIZE(48), .N_ENTRIES(4), .NB_ADDR(2),
                            .CONTROLLER_ID(CTRL_ID_MEMORY))
        dut_b (.i_clock(clk), .i_reset(rst_b), .bus(ifb));

    logic [31:0] src_a [32];
    logic [47:0] src_b [4];
    assign ifa.i_data_from_mips = src_a[ifa.o_addr];
    assign ifb.i_data_from_mips = src_b[ifb.o_addr];

    int checks = 0, errors = 0;
    logic [31:0] exp_a[$], exp_b[$];
    bit pend_a = 0, pend_b = 0;
    int done_a = 0, done_b = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Monitors: pop/compare on every transfer, verify hold-while-stalled and done.
    bit hold_a = 0, hold_b = 0, pab = 0, pbb = 0;
    logic [31:0] held_a, held_b;
    always @(negedge clk) begin
        if (rst_a) hold_a = 0;
        else begin
            if (hold_a && !pab) begin
                check("a_hold_valid", ifa.o_frame_valid, 1);
                check("a_hold_frame", ifa.o_frame, held_a);
            end
            if (ifa.o_frame_valid && ifa.i_frame_ready) begin
                if (exp_a.size() == 0) check("a_unexpected_frame", ifa.o_frame_valid, 0);
                else check("a_frame", ifa.o_frame, exp_a.pop_front());
            end
            if (ifa.o_done) begin
                check("a_done_expected", pend_a, 1);
                check("a_done_queue_left", exp_a.size(), 0);
                pend_a = 0;
                done_a++;
            end
            hold_a = ifa.o_frame_valid && !ifa.i_frame_ready;
            held_a = ifa.o_frame;
            pab    = ifa.i_abort;
        end
    end
    always @(negedge clk) begin
        if (rst_b) hold_b = 0;
        else begin
            if (hold_b && !pbb) begin
                check("b_hold_valid", ifb.o_frame_valid, 1);
                check("b_hold_frame", ifb.o_frame, held_b);
            end
            if (ifb.o_frame_valid && ifb.i_frame_ready) begin
                if (exp_b.size() == 0) check("b_unexpected_frame", ifb.o_frame_valid, 0);
                else check("b_frame", ifb.o_frame, exp_b.pop_front());
            end
            if (ifb.o_done) begin
                check("b_done_expected", pend_b, 1);
                check("b_done_queue_left", exp_b.size(), 0);
                pend_b = 0;
                done_b++;
            end
            hold_b = ifb.o_frame_valid && !ifb.i_frame_ready;
            held_b = ifb.o_frame;
            pbb    = ifb.i_abort;
        end
    end

    // Ready generators (0 tied high, 1 random, 2 pattern 1-0-0-1, 3 held low).
    int mode_a = 0, mode_b = 0, pat_n = 0;
    bit mutate_b = 0;
    logic [3:0] pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        ifa.i_frame_ready = (mode_a == 0) ? 1'b1 : (mode_a == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        case (mode_b)
            0: ifb.i_frame_ready = 1'b1;
            1: ifb.i_frame_ready = 1'($urandom_range(0, 1));
            2: ifb.i_frame_ready = pat[pat_n % 4];
            default: ifb.i_frame_ready = 1'b0;
        endcase
        pat_n++;
        if (mutate_b && ifb.o_frame_valid) src_b[ifb.o_addr] = 48'({$urandom(), $urandom()});
    end

    // Reference model: entries in address order, each split MSB-first after zero padding.
    task automatic push_a();
        for (int k = 0; k < 32; k++) exp_a.push_back(src_a[k]);
        pend_a = 1;
    endtask
    task automatic push_b(input bit const_first);
        logic [63:0] p;
        for (int k = 0; k < 4; k++) begin
            p = {src_b[k], 16'h0000};
            if (k == 0 && const_first) begin
                exp_b.push_back(32'h12345678);
                exp_b.push_back(32'h9ABC0000);
            end else begin
                exp_b.push_back(p[63:32]);
                exp_b.push_back(p[31:0]);
            end
        end
        pend_b = 1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic req_a(input logic [5:0] sel);
        ifa.i_request_select = sel; ifa.i_request_valid = 1'b1; cyc(1); ifa.i_request_valid = 1'b0;
    endtask
    task automatic req_b(input logic [5:0] sel);
        ifb.i_request_select = sel; ifb.i_request_valid = 1'b1; cyc(1); ifb.i_request_valid = 1'b0;
    endtask
    // n counts cycles with the one after the request edge as cycle 1.
    task automatic wait_done_a(input int budget, output int n);
        n = 1;
        while (!ifa.o_done && n < budget) begin cyc(1); n++; end
        if (!ifa.o_done) check("a_done_timeout", ifa.o_done, 1);
    endtask
    task automatic wait_done_b(input int budget, output int n);
        n = 1;
        while (!ifb.o_done && n < budget) begin cyc(1); n++; end
        if (!ifb.o_done) check("b_done_timeout", ifb.o_done, 1);
    endtask

    task automatic check_reset_b(input string tag);
        check({tag, "_frame"}, ifb.o_frame, 0);
        check({tag, "_valid"}, ifb.o_frame_valid, 0);
        check({tag, "_busy"}, ifb.o_busy, 0);
        check({tag, "_done"}, ifb.o_done, 0);
        check({tag, "_addr"}, ifb.o_addr, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n, k;
        rst_a = 1; rst_b = 1;
        ifa.i_request_valid = 0; ifa.i_request_select = '0; ifa.i_abort = 0; ifa.i_frame_ready = 1;
        ifb.i_request_valid = 0; ifb.i_request_select = '0; ifb.i_abort = 0; ifb.i_frame_ready = 1;
        for (int i = 0; i < 32; i++) src_a[i] = 32'hA5000000 + 32'(i);
        for (int i = 0; i < 4; i++) src_b[i] = 48'({$urandom(), $urandom()});
        cyc(3);
        check("a_rst_frame", ifa.o_frame, 0);
        check("a_rst_valid", ifa.o_frame_valid, 0);
        check("a_rst_busy", ifa.o_busy, 0);
        check("a_rst_done", ifa.o_done, 0);
        check("a_rst_addr", ifa.o_addr, 0);
        check_reset_b("b_rst");
        rst_a = 0; rst_b = 0;
        cyc(1);

        // Regfile dump with ready high: 65-cycle completion.
        push_a();
        req_a(CTRL_ID_REGFILE);
        check("a_fetch_busy", ifa.o_busy, 1);
        check("a_fetch_addr", ifa.o_addr, 0);
        wait_done_a(200, n);
        check("a_done_latency", n, 65);
        cyc(1);
        check("a_done_pulse_len", ifa.o_done, 0);
        check("a_idle_busy", ifa.o_busy, 0);

        // Foreign controller ID is ignored.
        req_a(6'b100000);
        check("a_mismatch_busy", ifa.o_busy, 0);
        cyc(3);
        check("a_mismatch_valid", ifa.o_frame_valid, 0);

        // Matching request while busy is ignored; random backpressure.
        for (int i = 0; i < 32; i++) src_a[i] = $urandom();
        mode_a = 1;
        push_a();
        req_a(CTRL_ID_REGFILE);
        cyc(10);
        req_a(CTRL_ID_REGFILE);
        wait_done_a(400, n);
        cyc(6);
        check("a_busy_req_done_count", done_a, 2);
        check("a_busy_req_idle", ifa.o_busy, 0);

        // Abort during entry 3, then restart from address 0.
        mode_a = 0;
        cyc(1);
        push_a();
        req_a(CTRL_ID_REGFILE);
        k = 0;
        while (!(ifa.o_addr == 5'd3 && ifa.o_frame_valid) && k < 100) begin cyc(1); k++; end
        check("a_reach_entry3", ifa.o_addr, 3);
        ifa.i_abort = 1'b1;
        cyc(1);
        ifa.i_abort = 1'b0;
        exp_a.delete();
        pend_a = 0;
        check("a_abort_busy", ifa.o_busy, 0);
        check("a_abort_valid", ifa.o_frame_valid, 0);
        check("a_abort_addr_held", ifa.o_addr, 3);
        cyc(5);
        check("a_abort_no_done", done_a, 2);
        push_a();
        req_a(CTRL_ID_REGFILE);
        check("a_restart_addr", ifa.o_addr, 0);
        wait_done_a(200, n);
        cyc(2);
        check("a_restart_done_count", done_a, 3);

        // 48-bit entries: two frames each, LSB frame zero padded.
        src_b[0] = 48'h123456789ABC;
        push_b(1);
        req_b(CTRL_ID_MEMORY);
        wait_done_b(100, n);
        check("b_done_latency", n, 13);
        cyc(2);

        // Random ready with the source changing under the shadow register.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) src_b[i] = 48'({$urandom(), $urandom()});
            mode_b = 1; mutate_b = 1;
            cyc(1);
            push_b(0);
            req_b(CTRL_ID_MEMORY);
            wait_done_b(300, n);
            mutate_b = 0;
            cyc(2);
        end

        // Ready pattern 1-0-0-1.
        mode_b = 2;
        push_b(0);
        req_b(CTRL_ID_MEMORY);
        wait_done_b(300, n);
        cyc(2);
        check("b_done_count", done_b, 5);

        // Reset in the middle of SEND with ready low, then a clean dump.
        mode_b = 3;
        cyc(1);
        push_b(0);
        req_b(CTRL_ID_MEMORY);
        k = 0;
        while (!ifb.o_frame_valid && k < 20) begin cyc(1); k++; end
        check("b_stall_valid", ifb.o_frame_valid, 1);
        cyc(2);
        rst_b = 1;
        cyc(1);
        check_reset_b("b_midrst");
        rst_b = 0;
        exp_b.delete();
        pend_b = 0;
        mode_b = 0;
        cyc(1);
        push_b(0);
        req_b(CTRL_ID_MEMORY);
        wait_done_b(100, n);
        check("b_post_reset_latency", n, 13);
        cyc(3);
        check("b_final_done_count", done_b, 6);
        check("b_final_busy", ifb.o_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
